logic_gate_unit_bf: RTL and testbench
=====================================

// Module: logic_gate_unit_bf
// PURPOSE
//  Parametrised, registered successor to the single-bit inverter: WIDTH-bit two-operand
//  gate unit with a runtime-selected operation (NOT, AND, OR, XOR, ...). Results are
//  buffered in a DEPTH-entry output FIFO with valid/ready handshakes on both sides.
//  Sits between a stimulus/producer stage and a consumer in the gate-level lab datapath.
// PARAMETERS
//  WIDTH  1   operand/result width in bits (>=1)
//  DEPTH  2   output FIFO entries (power of 2, >=2)
//  CNT_W  16  width of optional transfer counter
// PORTS
//  clk       in   1      rising-edge clock
//  rst_n     in   1      asynchronous active-low reset
//  a         in   WIDTH  operand A
//  b         in   WIDTH  operand B (ignored for BUF/NOT)
//  op        in   3      operation select, sampled with a/b
//  in_valid  in   1      producer has a valid operand set
//  in_ready  out  1      unit can accept this cycle
//  y         out  WIDTH  result at FIFO head
//  y_valid   out  1      y is valid
//  y_ready   in   1      consumer accepts y this cycle
//  op_count  out  CNT_W  accepted-transfer count (only with GATE_OP_COUNT_EN)
// BEHAVIOUR
//  - Reset is asynchronous and active-low on rst_n; single clock clk.
//  - Reset (rst_n=0, async): FIFO empty, y=0, y_valid=0, in_ready=0 while held low,
//    op_count=0. in_ready=1 from the first clk edge after rst_n rises (FIFO empty).
//  - op: 000 BUF a | 001 NOT a | 010 a&b | 011 a|b | 100 ~(a&b) | 101 ~(a|b)
//    | 110 a^b | 111 ~(a^b). Bitwise, result exactly WIDTH bits, no carries.
//  - Push = in_valid & in_ready; result computed combinationally, written on that edge.
//  - Pop  = y_valid & y_ready; head advances on that edge.
//  - Latency: push at edge k into empty FIFO -> y/y_valid valid after edge k (1 cycle).
//  - in_ready = (occupancy < DEPTH), registered-state only; no comb path y_ready->in_ready.
//  - Full: in_ready=0; push blocked even if pop occurs same cycle; in_ready=1 next cycle.
//  - Empty: y_valid=0; y holds last popped value (0 after reset); pop ignored.
//  - Simultaneous push+pop when 0<occupancy<DEPTH: occupancy unchanged, order kept.
//  - Pointers wrap modulo DEPTH; occupancy counter log2(DEPTH)+1 bits.
//  - y/y_valid stable while y_valid=1 & y_ready=0 (no drop, no change).
//  - a/b/op change while in_valid=0 or in_ready=0: no effect.
//  - Reset mid-operation: all buffered results discarded immediately, no partial output.
// CONFIGURATION
//  GATE_OP_COUNT_EN defined: op_count port exists; increments by 1 on every push,
//   wraps (2^CNT_W-1)->0, cleared by reset, unaffected by pops.
//  GATE_OP_COUNT_EN undefined: op_count port and counter logic absent; all other
//   behaviour identical.
// TESTING (WIDTH=4, DEPTH=2 unless stated)
//  1 Reset: rst_n=0 mid-stream with 2 entries queued -> y_valid=0,y=0 same cycle; in_ready=1 edge after release.
//  2 All ops: a=4'b1100,b=4'b1010,y_ready=1, op 0..7 -> y=C,3,8,E,7,1,6,9 each 1 cycle after push.
//  3 Backpressure: y_ready=0, push 3 -> in_ready=0 after 2nd push, 3rd stalled; y stable at 1st result.
//  4 Full + pop: FIFO full, y_ready=1 & in_valid=1 same cycle -> pop only; push accepted next cycle; order preserved.
//  5 Streaming: in_valid=y_ready=1 for 20 cycles, random a/b/op -> 20 results in order, y_valid=1 continuously after cycle 1.
//  6 GATE_OP_COUNT_EN, CNT_W=4: 17 pushes -> op_count=1 (wrap); without macro bench compiles without op_count.

Source files
------------

// File: rtl/logic_gate_unit_bf.sv
`default_nettype none
// ============================================================================
// Module      : logic_gate_unit_bf
// Description : WIDTH-bit two-operand gate unit. The operation is selected at
//               runtime by op. Each accepted operand set produces one result,
//               which is queued in a DEPTH-entry output FIFO. Both sides use
//               valid/ready handshakes.
//               Ports:
//                 clk, rst_n          clock, asynchronous active-low reset
//                 a, b, op            operands and operation select
//                                     (op: 0 BUF a, 1 NOT a, 2 AND, 3 OR,
//                                      4 NAND, 5 NOR, 6 XOR, 7 XNOR)
//                 in_valid, in_ready  producer handshake
//                 y, y_valid, y_ready consumer handshake, y = FIFO head
//                 op_count            accepted-transfer counter, present only
//                                     when GATE_OP_COUNT_EN is defined
//               Build option: GATE_OP_COUNT_EN adds the op_count port/counter.
// Revision    : 1.0 - initial release
// ============================================================================
module logic_gate_unit_bf #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] y,
    output logic             y_valid,
    input  logic             y_ready
`ifdef GATE_OP_COUNT_EN
    ,
    output logic [CNT_W-1:0] op_count
`endif
);

    localparam int c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_occ_w = $clog2(DEPTH) + 1;
    localparam logic [c_occ_w-1:0] c_depth = c_occ_w'(DEPTH);

    // Reject unusable parameter sets at elaboration time.
    generate
        if ((WIDTH < 1) || (DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) || (CNT_W < 1)) begin : g_param_error
            $error("logic_gate_unit_bf: invalid WIDTH/DEPTH/CNT_W");
        end
    endgenerate

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_occ_w-1:0] r_occ;
    logic               r_in_ready;
    logic [WIDTH-1:0]   r_y_hold;

    logic               w_push;
    logic               w_pop;
    logic [c_occ_w-1:0] w_occ_next;
    logic [WIDTH-1:0]   w_result;

    // in_ready comes straight from a flop, so y_ready never reaches it
    // combinationally; a pop into a full FIFO reopens the input next cycle.
    assign w_push = in_valid & r_in_ready;
    assign w_pop  = (r_occ != '0) & y_ready;

    always_comb begin
        w_result = '0;
        case (op)
            3'b000:  w_result = a;
            3'b001:  w_result = ~a;
            3'b010:  w_result = a & b;
            3'b011:  w_result = a | b;
            3'b100:  w_result = ~(a & b);
            3'b101:  w_result = ~(a | b);
            3'b110:  w_result = a ^ b;
            default: w_result = ~(a ^ b);
        endcase
    end

    always_comb begin
        w_occ_next = r_occ;
        case ({w_push, w_pop})
            2'b10:   w_occ_next = r_occ + c_occ_w'(1);
            2'b01:   w_occ_next = r_occ - c_occ_w'(1);
            default: w_occ_next = r_occ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_occ      <= '0;
            r_in_ready <= 1'b0;
            r_y_hold   <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
                // Remember the departing head so y stays put once empty.
                r_y_hold <= r_mem[r_rd_ptr];
            end
            r_occ      <= w_occ_next;
            r_in_ready <= (w_occ_next < c_depth);
        end
    end

    // Storage needs no reset: an entry is only visible after it is written.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_result;
        end
    end

    assign in_ready = r_in_ready;
    assign y_valid  = (r_occ != '0);
    assign y        = y_valid ? r_mem[r_rd_ptr] : r_y_hold;

`ifdef GATE_OP_COUNT_EN
    logic [CNT_W-1:0] r_op_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op_count <= '0;
        end else if (w_push) begin
            r_op_count <= r_op_count + CNT_W'(1);
        end
    end

    assign op_count = r_op_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_logic_gate_unit_bf.sv
`default_nettype none
// ============================================================================
// Module      : tb_logic_gate_unit_bf
// Description : Self-checking bench for logic_gate_unit_bf (WIDTH=4, DEPTH=2).
//               A queue-based reference model tracks the expected FIFO
//               contents; every falling clock edge the DUT outputs are
//               compared against it. Directed literal checks pin the model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_logic_gate_unit_bf;

    localparam int WIDTH = 4;
    localparam int DEPTH = 2;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic [2:0]       op = '0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] y;
    logic             y_valid;
    logic             y_ready = 1'b0;
`ifdef GATE_OP_COUNT_EN
    logic [CNT_W-1:0] op_count;
`endif

    int vectors = 0;
    int miscompares = 0;

    logic_gate_unit_bf #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .op(op),
        .in_valid(in_valid), .in_ready(in_ready),
        .y(y), .y_valid(y_valid), .y_ready(y_ready)
`ifdef GATE_OP_COUNT_EN
        , .op_count(op_count)
`endif
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Each op is a 2-input truth table indexed by {a_bit, b_bit}.
    function automatic logic [WIDTH-1:0] gate(input logic [WIDTH-1:0] fa,
                                              input logic [WIDTH-1:0] fb,
                                              input logic [2:0] fop);
        logic [3:0] tt;
        logic [WIDTH-1:0] r;
        case (fop)
            3'd0: tt = 4'b1100;
            3'd1: tt = 4'b0011;
            3'd2: tt = 4'b1000;
            3'd3: tt = 4'b1110;
            3'd4: tt = 4'b0111;
            3'd5: tt = 4'b0001;
            3'd6: tt = 4'b0110;
            default: tt = 4'b1001;
        endcase
        for (int i = 0; i < WIDTH; i++) r[i] = tt[{fa[i], fb[i]}];
        return r;
    endfunction

    logic [WIDTH-1:0] mq[$];
    logic [WIDTH-1:0] m_last = '0;
    bit               m_ready = 1'b0;
    int               m_count = 0;

    always @(negedge rst_n) begin
        mq.delete();
        m_last  = '0;
        m_ready = 1'b0;
        m_count = 0;
    end

    always @(posedge clk) begin
        if (rst_n) begin
            bit push, pop;
            push = in_valid && m_ready;
            pop  = (mq.size() > 0) && y_ready;
            if (pop) m_last = mq.pop_front();
            if (push) begin
                mq.push_back(gate(a, b, op));
                m_count = (m_count + 1) % (1 << CNT_W);
            end
            m_ready = (mq.size() < DEPTH);
        end
    end

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        logic [WIDTH-1:0] ey;
        ey = (mq.size() > 0) ? mq[0] : m_last;
        check("in_ready", int'(in_ready), int'(m_ready));
        check("y_valid", int'(y_valid), int'(mq.size() > 0));
        check("y", int'(y), int'(ey));
`ifdef GATE_OP_COUNT_EN
        check("op_count", int'(op_count), m_count);
`endif
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
    endtask

    logic [WIDTH-1:0] lit [8];

    initial begin
        lit = '{4'hC, 4'h3, 4'h8, 4'hE, 4'h7, 4'h1, 4'h6, 4'h9};
        #1;
        rst_n = 1'b0;
        #1;
        check("reset_in_ready", int'(in_ready), 0);
        check("reset_y_valid", int'(y_valid), 0);
        check("reset_y", int'(y), 0);
        step();
        rst_n = 1'b1;
        step();
        check("ready_after_release", int'(in_ready), 1);

        // All ops, streaming with y_ready=1
        a = 4'b1100; b = 4'b1010; y_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            op = 3'(i); in_valid = 1'b1;
            step();
            check("op_literal", int'(y), int'(lit[i]));
            check("op_literal_valid", int'(y_valid), 1);
        end
        in_valid = 1'b0;
        step();

        // Backpressure: three pushes, only two accepted
        do_reset();
        y_ready = 1'b0; in_valid = 1'b1;
        op = 3'd0; step();
        check("bp_ready1", int'(in_ready), 1);
        op = 3'd1; step();
        check("bp_ready2", int'(in_ready), 0);
        op = 3'd2; step();
        check("bp_stall_ready", int'(in_ready), 0);
        check("bp_head", int'(y), 4'hC);

        // Full + pop same cycle: pop only, then push accepted
        op = 3'd6; y_ready = 1'b1;
        step();
        check("fullpop_head", int'(y), 4'h3);
        check("fullpop_ready", int'(in_ready), 1);
        step();
        check("push_after_full", int'(y), 4'h6);
        in_valid = 1'b0;
        step();
        check("empty_valid", int'(y_valid), 0);
        check("empty_hold", int'(y), 4'h6);

        // Reset with two entries queued
        y_ready = 1'b0; in_valid = 1'b1; op = 3'd3;
        step(); step();
        rst_n = 1'b0;
        #1;
        check("midreset_y_valid", int'(y_valid), 0);
        check("midreset_y", int'(y), 0);
        check("midreset_ready", int'(in_ready), 0);
        in_valid = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        check("midreset_ready_after", int'(in_ready), 1);

        // Streaming 20 random transfers
        in_valid = 1'b1; y_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            a = 4'($urandom); b = 4'($urandom); op = 3'($urandom);
            step();
            check("stream_valid", int'(y_valid), 1);
        end
        in_valid = 1'b0;
        step(); step();

        // Randomized traffic with an occasional reset
        for (int i = 0; i < 400; i++) begin
            a = 4'($urandom); b = 4'($urandom); op = 3'($urandom);
            in_valid = ($urandom_range(0, 3) != 0);
            y_ready  = ($urandom_range(0, 1) != 0);
            if (i == 200) begin
                rst_n = 1'b0;
                #2;
                rst_n = 1'b1;
            end
            step();
        end

`ifdef GATE_OP_COUNT_EN
        do_reset();
        in_valid = 1'b1; y_ready = 1'b1;
        repeat (17) step();
        in_valid = 1'b0;
        check("op_count_wrap", int'(op_count), 1);
        step();
`endif

        in_valid = 1'b0;
        step();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
